// File: rtl/count_bank.sv
// Decimal event-counter bank: BCD digits incremented per trigger line on an
// increment strobe, with carries rippling one digit per clock.
module count_bank #(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     trigger,
    input  logic                  inc_pulse,
    input  logic                  ref_pulse,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic                  busy,
    output logic                  overflow
);

    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

    typedef enum logic {IDLE, RIPPLE} state_t;

    state_t                state_reg,    state_next;
    logic [4*DIGITS-1:0]   count_reg,    count_next;
    logic [DIGITS-1:0]     pending_reg,  pending_next;
    logic                  carry_reg,    carry_next;
    logic [KW-1:0]         k_reg,        k_next;
    logic                  overflow_reg, overflow_next;
    logic                  ref_pend_reg, ref_pend_next;
    logic [4*DIGITS-1:0]   disp_reg,     disp_next;

    logic [3:0] digit_w [DIGITS];
    logic [3:0] cur_digit;
    logic [4:0] sum;
    logic [3:0] digit_new;
    logic       carry_out;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_w[gi] = count_reg[4*gi +: 4];
        end
    endgenerate

    // Single-digit BCD add: at most 9 + 1 + 1 = 11, so one correction step suffices.
    always_comb begin
        cur_digit = digit_w[k_reg];
        sum       = 5'(cur_digit) + 5'(pending_reg[k_reg]) + 5'(carry_reg);
        carry_out = (sum >= 5'd10);
        digit_new = carry_out ? 4'(sum - 5'd10) : sum[3:0];
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        pending_next  = pending_reg;
        carry_next    = carry_reg;
        k_next        = k_reg;
        overflow_next = overflow_reg;
        ref_pend_next = ref_pend_reg;
        disp_next     = disp_reg;

        if (clr) begin
            state_next    = IDLE;
            count_next    = '0;
            pending_next  = '0;
            carry_next    = 1'b0;
            k_next        = '0;
            overflow_next = 1'b0;
            ref_pend_next = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (inc_pulse) begin
                        pending_next = trigger;
                        k_next       = '0;
                        carry_next   = 1'b0;
                        state_next   = RIPPLE;
                        if (ref_pulse)
                            ref_pend_next = 1'b1;
                    end else if (ref_pulse) begin
                        disp_next = count_reg;
                    end
                end
                RIPPLE: begin
                    count_next[4*int'(k_reg) +: 4] = digit_new;
                    carry_next = carry_out;
                    if (ref_pulse)
                        ref_pend_next = 1'b1;
                    if (k_reg == K_LAST) begin
                        if (carry_out)
                            overflow_next = 1'b1;
                        state_next = IDLE;
                        // A refresh seen during (or on the last edge of) the ripple gets the settled count.
                        if (ref_pend_reg || ref_pulse)
                            disp_next = count_next;
                        ref_pend_next = 1'b0;
                    end else begin
                        k_next = k_reg + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            pending_reg  <= '0;
            carry_reg    <= 1'b0;
            k_reg        <= '0;
            overflow_reg <= 1'b0;
            ref_pend_reg <= 1'b0;
            disp_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            pending_reg  <= pending_next;
            carry_reg    <= carry_next;
            k_reg        <= k_next;
            overflow_reg <= overflow_next;
            ref_pend_reg <= ref_pend_next;
            disp_reg     <= disp_next;
        end
    end

    assign digits_out = disp_reg;
    assign busy       = (state_reg == RIPPLE);
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_count_bank.sv
// Self-checking bench for count_bank: vector table, hand-written corner
// sequences and randomized increments against a decimal-arithmetic model.
module tb_count_bank;

    localparam int D   = 6;
    localparam int MOD = 1000000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [D-1:0]     trigger;
    logic             inc_pulse;
    logic             ref_pulse;
    logic             clr;
    logic [4*D-1:0]   digits_out;
    logic             busy;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    count_bank #(.DIGITS(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trigger    (trigger),
        .inc_pulse  (inc_pulse),
        .ref_pulse  (ref_pulse),
        .clr        (clr),
        .digits_out (digits_out),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [D-1:0] trig;
        int           start;
        int           exp_count;
        bit           exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int x;
        x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int trig_value(input logic [D-1:0] t);
        int v, w;
        v = 0;
        w = 1;
        for (int i = 0; i < D; i++) begin
            if (t[i]) v += w;
            w *= 10;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            step();
        end
        if (cycles >= 40) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_inc(input logic [D-1:0] t, output int busy_cycles);
        trigger   = t;
        inc_pulse = 1'b1;
        step();
        inc_pulse = 1'b0;
        trigger   = '0;
        wait_idle(busy_cycles);
    endtask

    task automatic do_ref();
        ref_pulse = 1'b1;
        step();
        ref_pulse = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    // Clear, then build a decimal value by stepping each digit up one unit per increment.
    task automatic preload(input int v);
        logic [D-1:0] t;
        int bc;
        do_clr();
        for (int n = 1; n <= 9; n++) begin
            for (int i = 0; i < D; i++) t[i] = ((v / (10 ** i)) % 10) >= n;
            if (t != '0) run_inc(t, bc);
        end
    endtask

    vec_t vecs[10];
    int   bc;
    int   model;
    bit   model_ovf;

    initial begin
        vecs[0] = '{6'b000001, 0,      1,      1'b0};
        vecs[1] = '{6'b000001, 9,      10,     1'b0};
        vecs[2] = '{6'b000001, 999999, 0,      1'b1};
        vecs[3] = '{6'b000011, 0,      11,     1'b0};
        vecs[4] = '{6'b000011, 99,     110,    1'b0};
        vecs[5] = '{6'b111111, 999999, 111110, 1'b1};
        vecs[6] = '{6'b100000, 900000, 0,      1'b1};
        vecs[7] = '{6'b000000, 12345,  12345,  1'b0};
        vecs[8] = '{6'b101010, 90909,  191919, 1'b0};
        vecs[9] = '{6'b010101, 989898, 999999, 1'b0};

        rst_n = 1'b0; trigger = '0; inc_pulse = 1'b0; ref_pulse = 1'b0; clr = 1'b0;
        step(); step();
        check("reset_digits", 32'(digits_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 10; v++) begin
            preload(vecs[v].start);
            run_inc(vecs[v].trig, bc);
            check($sformatf("vec%0d_busy_cycles", v), 32'(bc), 32'(D));
            do_ref();
            check($sformatf("vec%0d_digits", v), 32'(digits_out), 32'(to_bcd(vecs[v].exp_count)));
            check($sformatf("vec%0d_ovf", v), 32'(overflow), 32'(vecs[v].exp_ovf));
        end

        // Overflow survives a refresh and is cleared only by clr.
        preload(999999);
        run_inc(6'b000001, bc);
        do_ref();
        check("ovf_ref_digits", 32'(digits_out), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        step(); step();
        check("ovf_still", 32'(overflow), 32'd1);
        do_clr();
        check("ovf_clr", 32'(overflow), 32'd0);

        // Refresh at T+2 is deferred to T+6; inc at T+3 is dropped.
        preload(9);
        do_ref();
        check("defer_pre", 32'(digits_out), 32'h9);
        trigger = 6'b000001; inc_pulse = 1'b1;
        step();
        inc_pulse = 1'b0;
        step();
        ref_pulse = 1'b1;
        step();
        ref_pulse = 1'b0; inc_pulse = 1'b1;
        step();
        inc_pulse = 1'b0; trigger = '0;
        check("defer_t3", 32'(digits_out), 32'h9);
        step(); step();
        check("defer_t5", 32'(digits_out), 32'h9);
        check("defer_t5_busy", 32'(busy), 32'd1);
        step();
        check("defer_t6", 32'(digits_out), 32'h10);
        check("defer_t6_busy", 32'(busy), 32'd0);
        step(); step();
        check("drop_busy", 32'(busy), 32'd0);
        do_ref();
        check("drop_final", 32'(digits_out), 32'h10);

        // Asynchronous reset in the middle of a ripple.
        preload(123);
        do_ref();
        trigger = 6'b000001; inc_pulse = 1'b1;
        step();
        inc_pulse = 1'b0; trigger = '0;
        step(); step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_digits", 32'(digits_out), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        step();
        rst_n = 1'b1;
        step(); step(); step();
        check("arst_after_busy", 32'(busy), 32'd0);
        do_ref();
        check("arst_count", 32'(digits_out), 32'd0);

        // clr wins over inc_pulse on the same edge; display keeps its snapshot.
        preload(5);
        do_ref();
        clr = 1'b1; inc_pulse = 1'b1; trigger = 6'b000001;
        step();
        clr = 1'b0; inc_pulse = 1'b0; trigger = '0;
        check("clr_inc_busy", 32'(busy), 32'd0);
        check("clr_keeps_disp", 32'(digits_out), 32'h5);
        do_ref();
        check("clr_count", 32'(digits_out), 32'd0);

        // Randomized increments against decimal arithmetic.
        do_clr();
        model = 0;
        model_ovf = 1'b0;
        for (int it = 0; it < 60; it++) begin
            logic [D-1:0] t;
            int d;
            if ($urandom_range(0, 19) == 0) begin
                do_clr();
                model = 0;
                model_ovf = 1'b0;
            end
            t = D'($urandom);
            d = $urandom_range(0, 8);
            trigger = t; inc_pulse = 1'b1;
            step();
            inc_pulse = 1'b0; trigger = '0;
            model += trig_value(t);
            if (model >= MOD) begin
                model -= MOD;
                model_ovf = 1'b1;
            end
            if (d <= 5) begin
                for (int s = 0; s < d; s++) step();
                do_ref();
            end
            wait_idle(bc);
            if (d > 5) do_ref();
            check($sformatf("rand%0d_digits", it), 32'(digits_out), 32'(to_bcd(model)));
            check($sformatf("rand%0d_ovf", it), 32'(overflow), 32'(model_ovf));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_bank.md
# count_bank

Decimal event-counter bank that consumes the one-cycle increment and refresh strobes issued by the trigger/debounce stage. It holds DIGITS BCD digits, adds 1 to every digit whose trigger line is high when an increment strobe arrives, and ripples carries one digit per clock. On a refresh strobe it snapshots the settled count into the display register that feeds the output driver.

## Interface
- DIGITS, 6, number of BCD digits; legal range 1..16, so a full ripple completes inside the 16-cycle calculation window of the strobe generator.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- trigger  input  DIGITS  synchronised trigger levels; bit i selects a +1 to digit i (weight 10^i).
- inc_pulse  input  1  one-cycle increment strobe.
- ref_pulse  input  1  one-cycle refresh strobe.
- clr  input  1  synchronous clear of the count and overflow.
- digits_out  output  4*DIGITS  display snapshot; digit i in bits [4i+3:4i].
- busy  output  1  high while a carry ripple is in progress.
- overflow  output  1  sticky; set when a carry leaves the top digit.

## Operation
- Reset (rst_n=0, asynchronous): all count digits 0, digits_out 0, busy 0, overflow 0, state IDLE, pending-add vector 0, carry 0, ref_pend 0.
- State IDLE:
  - inc_pulse=1 and clr=0: latch pending[DIGITS-1:0] <= trigger; index k <= 0; carry <= 0; busy <= 1; go to RIPPLE.
  - trigger=0 when inc_pulse arrives: the ripple still runs and leaves the count unchanged.
- State RIPPLE, one digit per cycle:
  - Compute s = digit[k] + pending[k] + carry. The maximum is 11, so a 4-bit add into a 5-bit result is sufficient.
  - s >= 10: digit[k] <= s-10, carry <= 1. Otherwise digit[k] <= s, carry <= 0.
  - k < DIGITS-1: k <= k+1.
  - k == DIGITS-1: if a carry out is generated, set overflow <= 1 and leave the digits wrapped (for DIGITS=6, 999999 becomes 000000). Then busy <= 0 and go to IDLE.
- inc_pulse while in RIPPLE is ignored (dropped). No queueing.
- ref_pulse:
  - In IDLE, with no ripple starting on the same edge: digits_out <= count on that edge.
  - In RIPPLE, or on the same edge inc_pulse starts a ripple: set ref_pend. digits_out <= final count on the edge that leaves RIPPLE, and ref_pend clears.
- clr=1:
  - On any edge, clr zeroes all digits, pending, carry and overflow, aborts any ripple (busy <= 0, go to IDLE), and clears ref_pend.
  - clr has priority over inc_pulse and ref_pulse on the same edge.
  - digits_out is not modified by clr; it updates on the next ref_pulse.
- Digit values are always in 0..9. Values 10..15 are never produced.
- rst_n asserted mid-ripple: all state returns to reset values immediately. There is no partial update after deassertion.

## Timing
- inc_pulse sampled high at edge T (IDLE): busy is high from T through T+DIGITS-1 edges, i.e. for DIGITS cycles.
- Digit k is written at edge T+1+k. busy falls and state is IDLE after edge T+DIGITS.
- The count is final after edge T+DIGITS. The strobe generator's ref_pulse (about 17 cycles after inc) therefore sees a settled count for DIGITS <= 16.
- Deferred ref: digits_out updates at edge T+DIGITS, the same edge busy falls.
- overflow rises at edge T+DIGITS and stays high until clr or reset.
- Next inc_pulse is accepted on edge T+DIGITS+1 or later.

## Test plan
1. Reset, then trigger=6'b000001, inc_pulse at T -> busy high exactly 6 cycles; after T+6 the count is 000001; ref_pulse gives digits_out=24'h000001.
2. Count preloaded to 000009 by nine increments, then trigger=000001 + inc -> count 000010. The carry reaches digit 1 at edge T+2, and digits 2..5 stay 0.
3. Count 999999, trigger=000001 + inc -> count 000000 after T+6, overflow=1. ref gives digits_out=0 while overflow stays 1. clr -> overflow 0.
4. Count 000000, trigger=6'b000011 + inc -> count 000011. Count 000099, trigger=6'b000011 + inc -> count 000110.
5. ref_pulse at T+2 during a ripple from 000009 -> digits_out stays at the old value until edge T+6, then shows 000010. A second inc_pulse at T+3 is dropped, giving a final count of 000010.
6. rst_n pulsed low at T+3 of a ripple -> all outputs 0 asynchronously, and no busy afterwards. clr and inc_pulse on the same edge -> count 0, busy stays 0.
